ps2_keyboard_rx: RTL

- Receives device-to-host PS/2 frames from the board's USB-pin PS/2 port and buffers scan-code bytes in a small FIFO.
- Presents bytes as a valid/ready stream to the SoC peripheral bus.
- Runs entirely in the CPU clock domain and sits directly upstream of the gsoc keyboard register interface.

---
 rtl/ps2_keyboard_rx.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/ps2_keyboard_rx.sv
// PS/2 device-to-host receiver: input conditioning, frame FSM with timeout, and a
// registered show-ahead byte FIFO. Define PS2_HOST_INHIBIT_EN to hold ps2_clk low while full.
module ps2_keyboard_rx #(
  parameter int CLK_HZ     = 50000000,
  parameter int FIFO_DEPTH = 8,
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT_US = 2000
) (
  input  logic                          clk_cpu,
  input  logic                          reset_n_i,
  input  logic                          ps2_clk_i,
  input  logic                          ps2_data_i,
  output logic [7:0]                    data_o,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic [$clog2(FIFO_DEPTH):0]   count_o,
  output logic                          frame_err_o,
  output logic                          overflow_o,
  output logic                          ps2_clk_oe_o
);

  localparam int TMO_CYC = CLK_HZ / 1000000 * TIMEOUT_US;
  localparam int TMO_W   = $clog2(TMO_CYC + 1);
  localparam int FLT_W   = $clog2(FILTER_LEN + 1);
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  // Stage p0/p1: two-flop synchronisers, preset high (bus idle level)
  logic clk_p0, clk_p1, dat_p0, dat_p1;

  always_ff @(posedge clk_cpu or negedge reset_n_i) begin
    if (!reset_n_i) begin
      clk_p0 <= 1'b1;
      clk_p1 <= 1'b1;
      dat_p0 <= 1'b1;
      dat_p1 <= 1'b1;
    end else begin
      clk_p0 <= ps2_clk_i;
      clk_p1 <= clk_p0;
      dat_p0 <= ps2_data_i;
      dat_p1 <= dat_p0;
    end
  end

  // Stage p2: clock deglitch filter and falling-edge strobe
  logic             clk_flt;
  logic [FLT_W-1:0] flt_cnt;
  logic             fe_p2;
  logic             fe;

  always_ff @(posedge clk_cpu or negedge reset_n_i) begin
    if (!reset_n_i) begin
      clk_flt <= 1'b1;
      flt_cnt <= '0;
      fe_p2   <= 1'b0;
    end else begin
      fe_p2 <= 1'b0;
      if (clk_p1 != clk_flt) begin
        if (flt_cnt == FLT_W'(FILTER_LEN - 1)) begin
          clk_flt <= clk_p1;
          flt_cnt <= '0;
          fe_p2   <= clk_flt;
        end else begin
          flt_cnt <= flt_cnt + 1'b1;
        end
      end else begin
        flt_cnt <= '0;
      end
    end
  end

`ifdef PS2_HOST_INHIBIT_EN
  assign fe = fe_p2 & ~ps2_clk_oe_o;
`else
  assign fe = fe_p2;
`endif

  // Stage p3: frame FSM; shift register and parity bit are datapath, not reset
  state_t           state_q, state_d;
  logic [2:0]       bitcnt_q, bitcnt_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             par_q, par_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             err_nxt, push_nxt, push_p3;
  logic             tmo_hit;

  assign tmo_hit = (state_q != S_IDLE) && (tmo_q == TMO_W'(TMO_CYC - 1));

  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    shreg_d  = shreg_q;
    par_d    = par_q;
    err_nxt  = 1'b0;
    push_nxt = 1'b0;
    tmo_d    = (fe || state_q == S_IDLE) ? '0 : tmo_q + 1'b1;
    if (tmo_hit) begin
      state_d = S_IDLE;
      err_nxt = 1'b1;
    end else if (fe) begin
      unique case (state_q)
        S_IDLE: begin
          if (!dat_p1) begin
            state_d  = S_DATA;
            bitcnt_d = 3'd0;
          end else begin
            err_nxt = 1'b1;
          end
        end
        S_DATA: begin
          shreg_d  = {dat_p1, shreg_q[7:1]};
          bitcnt_d = bitcnt_q + 1'b1;
          if (bitcnt_q == 3'd7) state_d = S_PARITY;
        end
        S_PARITY: begin
          par_d   = dat_p1;
          state_d = S_STOP;
        end
        S_STOP: begin
          state_d = S_IDLE;
          if (dat_p1 && (^{shreg_q, par_q})) push_nxt = 1'b1;
          else                               err_nxt  = 1'b1;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_cpu or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= S_IDLE;
      bitcnt_q    <= 3'd0;
      tmo_q       <= '0;
      push_p3     <= 1'b0;
      frame_err_o <= 1'b0;
    end else begin
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      tmo_q       <= tmo_d;
      push_p3     <= push_nxt;
      frame_err_o <= err_nxt;
    end
  end

  always_ff @(posedge clk_cpu) begin
    shreg_q <= shreg_d;
    par_q   <= par_d;
  end

  // Stage p4: show-ahead FIFO; head byte is re-registered so it resets to zero
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr, rd_nxt;
  logic [CNT_W-1:0] count_d, remain;
  logic [7:0]       head_d;
  logic             full, pop, wr_en, ovf_nxt;

  assign full    = (count_o == CNT_W'(FIFO_DEPTH));
  assign pop     = valid_o & ready_i;
  assign wr_en   = push_p3 & (~full | pop);
  assign ovf_nxt = push_p3 & full & ~pop;
  assign rd_nxt  = rd_ptr + PTR_W'(pop);
  assign remain  = count_o - CNT_W'(pop);

  always_comb begin
    count_d = count_o;
    unique case ({wr_en, pop})
      2'b10:   count_d = count_o + CNT_W'(1);
      2'b01:   count_d = count_o - CNT_W'(1);
      default: count_d = count_o;
    endcase
    if (remain != '0) head_d = mem[rd_nxt];
    else if (wr_en)   head_d = shreg_q;
    else              head_d = 8'h00;
  end

  always_ff @(posedge clk_cpu) begin
    if (wr_en) mem[wr_ptr] <= shreg_q;
  end

  always_ff @(posedge clk_cpu or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_o    <= '0;
      valid_o    <= 1'b0;
      data_o     <= 8'h00;
      overflow_o <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      rd_ptr     <= rd_nxt;
      count_o    <= count_d;
      valid_o    <= (count_d != '0);
      data_o     <= head_d;
      overflow_o <= ovf_nxt;
    end
  end

`ifdef PS2_HOST_INHIBIT_EN
  // Only engage between frames; once engaged, hold until space frees up.
  always_ff @(posedge clk_cpu or negedge reset_n_i) begin
    if (!reset_n_i) ps2_clk_oe_o <= 1'b0;
    else            ps2_clk_oe_o <= full & (ps2_clk_oe_o | (state_q == S_IDLE));
  end
`else
  assign ps2_clk_oe_o = 1'b0;
`endif

endmodule
